// File: rtl/char_hit_if.sv
// Game/video-side signal bundle for the character hit detector.
// The master drives the pixel and event inputs; the slave returns the hit status.
interface char_hit_if #(
   parameter int CNT_W = 12
);
   logic             start;
   logic             startOfFrame;
   logic             charDR;
   logic             ballDR;
   logic             charHit;
   logic             graceActive;
   logic [CNT_W-1:0] lastOverlap;

   modport master (
      output start, startOfFrame, charDR, ballDR,
      input  charHit, graceActive, lastOverlap
   );

   modport slave (
      input  start, startOfFrame, charDR, ballDR,
      output charHit, graceActive, lastOverlap
   );
endinterface

// File: rtl/char_hit_detector.sv
// Counts character/ball overlap pixels per frame and raises one charHit
// pulse per game once a frame's overlap count reaches the threshold.
module char_hit_detector #(
   parameter int MIN_OVERLAP_PIX = 4,
   parameter int GRACE_FRAMES    = 60,
   parameter int CNT_W           = 12
) (
   input logic       clk,
   input logic       resetN,
   char_hit_if.slave bus
);

   localparam int GW = (GRACE_FRAMES < 2) ? 1 : $clog2(GRACE_FRAMES + 1);
   localparam logic [CNT_W-1:0] CMAX  = '1;
   localparam logic [CNT_W-1:0] MINV  = CNT_W'(MIN_OVERLAP_PIX);
   localparam logic [GW-1:0]    GLOAD = GW'(GRACE_FRAMES);

   typedef enum logic [1:0] {
      IDLE,
      GRACE,
      ARMED,
      HIT
   } state_t;

   state_t           state, stateNxt;
   logic [CNT_W-1:0] overlapCnt, cntNxt;
   logic [CNT_W-1:0] lastQ, lastNxt;
   logic [GW-1:0]    graceCnt, graceNxt;
   logic             hitQ, hitNxt;
   logic             ov;
   logic             sof;

   assign ov  = bus.charDR & bus.ballDR;
   assign sof = bus.startOfFrame;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= IDLE;
         overlapCnt <= '0;
         lastQ      <= '0;
         graceCnt   <= '0;
         hitQ       <= 1'b0;
      end else begin
         state      <= stateNxt;
         overlapCnt <= cntNxt;
         lastQ      <= lastNxt;
         graceCnt   <= graceNxt;
         hitQ       <= hitNxt;
      end
   end

   // start wins over any same-cycle SOF evaluation
   always_comb begin
      stateNxt = state;
      cntNxt   = overlapCnt;
      lastNxt  = lastQ;
      graceNxt = graceCnt;
      hitNxt   = 1'b0;
      if (bus.start) begin
         graceNxt = GLOAD;
         cntNxt   = '0;
         stateNxt = (GRACE_FRAMES == 0) ? ARMED : GRACE;
      end else begin
         unique case (state)
            IDLE: ;
            GRACE: begin
               cntNxt = '0;
               if (sof) begin
                  graceNxt = graceCnt - GW'(1);
                  if (graceCnt == GW'(1)) begin
                     stateNxt = ARMED;
                     cntNxt   = CNT_W'(ov);
                  end
               end
            end
            ARMED: begin
               if (sof) begin
                  lastNxt = overlapCnt;
                  cntNxt  = CNT_W'(ov);
                  if (overlapCnt >= MINV) begin
                     hitNxt   = 1'b1;
                     stateNxt = HIT;
                  end
               end else if (ov && (overlapCnt != CMAX)) begin
                  cntNxt = overlapCnt + CNT_W'(1);
               end
            end
            HIT: ;
            default: stateNxt = IDLE;
         endcase
      end
   end

   assign bus.charHit     = hitQ;
   assign bus.graceActive = (state == GRACE);
   assign bus.lastOverlap = lastQ;

endmodule
